seg_scan: RTL
=============

Name: seg_scan

Overview:
- Consumer end of the decimal-point command path: takes the 4-bit dp pattern plus four 4-bit digit values and drives a multiplexed 4-digit common-anode 7-segment display.
- Time-multiplexes the digits with a refresh divider and inserts a blanking guard at each digit switch.
- Latches all inputs once per frame, so the display never shows a torn frame mid-scan.
- Sits between the calculator datapath/dp logic and the board display pins.

Parameters:
- REFRESH_DIV, 16384, clock cycles per digit slot; legal range 4..65536.
- BLANK_CYCLES, 64, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- en  input  1  display enable; 0 = display dark and scan held
- digits  input  16  digit values; [3:0] = digit 0 (rightmost) ... [15:12] = digit 3
- dp  input  4  decimal-point pattern; bit i lights the dp of digit i
- seg_n  output  7  segments, active-low; bit0 = a ... bit6 = g
- dp_n  output  1  decimal point, active-low
- an_n  output  4  anode selects, active-low; bit i = digit i
- frame_start  output  1  one-cycle pulse when a new frame is latched

Behaviour:
- Reset (rst = 0, asynchronous):
  - div_cnt = 0, idx = 0, shadow digits and dp = 0.
  - an_n = 4'b1111, seg_n = 7'b1111111, dp_n = 1, frame_start = 0.
- Scan counter:
  - div_cnt counts 0..REFRESH_DIV-1 and wraps to 0.
  - On the wrap, idx advances 0→1→2→3→0. 2-bit wrap is intended.
- Frame latch:
  - On a rising edge with en = 1, idx = 0 and div_cnt = 0, the shadow registers capture digits and dp.
  - frame_start = 1 in the following cycle only.
  - Input changes at any other time have no visible effect until the next frame latch.
- Registered outputs, 1-cycle latency from (idx, div_cnt, shadow) to the pins:
  - While div_cnt < BLANK_CYCLES: an_n = 1111. seg_n and dp_n still carry the new digit's pattern, so the guard only blanks the anode.
  - Otherwise: an_n = ~(1 << idx), seg_n = decode(shadow digit idx), dp_n = ~shadow dp[idx].
- Hex decode (seg_n, written g..a):
  - 0 1000000, 1 1111001, 2 0100100, 3 0110000
  - 4 0011001, 5 0010010, 6 0000010, 7 1111000
  - 8 0000000, 9 0010000, A 0001000, b 0000011
  - C 1000110, d 0100001, E 0000110, F 0001110
- en = 0:
  - div_cnt and idx are forced to 0 synchronously.
  - an_n = 1111, seg_n = 1111111, dp_n = 1.
  - Shadow registers hold their value.
  - When en returns to 1, the first edge is a frame-latch edge.
- dp pattern 4'b1111 (all points lit) and 4'b0000 need no special casing; each bit is an independent lamp.
- Reset asserted mid-frame: all outputs go to their reset values immediately, without waiting for clk. The scan restarts at digit 0 after release.
- Only one slot's anode is ever active. No cycle may have two an_n bits low.

Test Plan (REFRESH_DIV = 8, BLANK_CYCLES = 2):
- Reset check: hold rst = 0, then release with en = 1, digits = 16'h1234, dp = 4'b0100.
  - frame_start pulses 1 cycle after the first edge.
  - Digit 0 slot: an_n = 1111 for 2 cycles, then 1110 for 6 cycles with seg_n = 0011001 ('4') and dp_n = 1.
- Same frame, digit 2 slot: an_n = 1011, seg_n = 0100100 ('2'), dp_n = 0.
- Tear check: change digits to 16'hFFFF during the idx = 1 slot.
  - Slots 2 and 3 still show '2' and '1'.
  - 'F' (0001110) appears only after the next frame_start.
- Decode sweep: across 16 frames with all digits = n (0..F), seg_n matches the table for every n.
- Enable check: drop en mid-slot.
  - Next cycle an_n = 1111, seg_n = 1111111, dp_n = 1.
  - Restore en: frame_start pulses and the scan resumes at digit 0.
- Async reset check: assert rst between clock edges while an_n = 0111.
  - an_n = 1111 before the next clk edge.
  - No frame_start until the first frame after release.
  - An assertion checks that at most one an_n bit is low on every cycle.

Source files
------------

// File: rtl/seg_scan.sv
// Multiplexed 4-digit common-anode 7-segment driver with per-frame input latching
// and an anode-off guard at the start of every digit slot.
module seg_scan #(
    parameter int unsigned REFRESH_DIV  = 16384,
    parameter int unsigned BLANK_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] digits,
    input  logic [3:0]  dp,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [3:0]  an_n,
    output logic        frame_start
);

    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] DIV_MAX = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] r_div_cnt;
    logic [1:0]    r_idx;
    logic [15:0]   r_shadow_dig;
    logic [3:0]    r_shadow_dp;

    logic          w_latch;
    logic          w_div_wrap;
    logic          w_blank;
    logic [15:0]   w_src_dig;
    logic [3:0]    w_src_dp;
    logic [3:0]    w_nib;
    logic          w_dp_bit;

    function automatic logic [6:0] f_decode(input logic [3:0] v);
        case (v)
            4'h0: f_decode = 7'b1000000;
            4'h1: f_decode = 7'b1111001;
            4'h2: f_decode = 7'b0100100;
            4'h3: f_decode = 7'b0110000;
            4'h4: f_decode = 7'b0011001;
            4'h5: f_decode = 7'b0010010;
            4'h6: f_decode = 7'b0000010;
            4'h7: f_decode = 7'b1111000;
            4'h8: f_decode = 7'b0000000;
            4'h9: f_decode = 7'b0010000;
            4'hA: f_decode = 7'b0001000;
            4'hB: f_decode = 7'b0000011;
            4'hC: f_decode = 7'b1000110;
            4'hD: f_decode = 7'b0100001;
            4'hE: f_decode = 7'b0000110;
            default: f_decode = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        w_latch    = en && (r_idx == 2'd0) && (r_div_cnt == '0);
        w_div_wrap = (r_div_cnt == DIV_MAX);
        w_blank    = 32'(r_div_cnt) < BLANK_CYCLES;
        // On the latch edge the fresh inputs feed the pattern so the guard
        // cycles already carry the new frame's digit 0 rather than stale data.
        w_src_dig  = w_latch ? digits : r_shadow_dig;
        w_src_dp   = w_latch ? dp : r_shadow_dp;
        w_nib      = w_src_dig[3:0];
        w_dp_bit   = w_src_dp[0];
        case (r_idx)
            2'd1: begin w_nib = w_src_dig[7:4];   w_dp_bit = w_src_dp[1]; end
            2'd2: begin w_nib = w_src_dig[11:8];  w_dp_bit = w_src_dp[2]; end
            2'd3: begin w_nib = w_src_dig[15:12]; w_dp_bit = w_src_dp[3]; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_cnt    <= '0;
            r_idx        <= '0;
            r_shadow_dig <= '0;
            r_shadow_dp  <= '0;
            seg_n        <= '1;
            dp_n         <= 1'b1;
            an_n         <= '1;
            frame_start  <= 1'b0;
        end else begin
            frame_start <= w_latch;
            if (w_latch) begin
                r_shadow_dig <= digits;
                r_shadow_dp  <= dp;
            end

            if (!en) begin
                r_div_cnt <= '0;
                r_idx     <= '0;
            end else if (w_div_wrap) begin
                r_div_cnt <= '0;
                r_idx     <= r_idx + 2'd1;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end

            if (!en) begin
                seg_n <= '1;
                dp_n  <= 1'b1;
                an_n  <= '1;
            end else begin
                seg_n <= f_decode(w_nib);
                dp_n  <= ~w_dp_bit;
                an_n  <= w_blank ? 4'b1111 : ~(4'b0001 << r_idx);
            end
        end
    end

endmodule
